// File: rtl/maze_pkg.sv
// Shared maze geometry, probe FSM states and direction indices for maze_wall_probe.
// The optional side-tunnel behaviour (MAZE_TUNNEL_WRAP_EN) lives in maze_probe_addr.
package maze_pkg;

  localparam int TILE_SHIFT = 4;
  localparam int MAP_W      = 40;
  localparam int MAP_H      = 30;
  localparam int BALL_S     = 4;
  localparam int STEP       = 1;

  localparam int DIR_L = 0;
  localparam int DIR_R = 1;
  localparam int DIR_U = 2;
  localparam int DIR_D = 3;

  localparam int NUM_PROBES = 8;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE,
    DRAIN,
    PUBLISH
  } probe_state_t;

  // Probes are ordered in pairs per direction: 0,1 L / 2,3 R / 4,5 U / 6,7 D.
  function automatic logic [1:0] probe_dir(input logic [2:0] k);
    return k[2:1];
  endfunction

endpackage

// File: rtl/maze_probe_addr.sv
// Combinational probe-point generator: maps (px, py, k) to a tile ROM address plus range flags.
// With MAZE_TUNNEL_WRAP_EN defined, horizontal probes off the left/right edge report tunnel_ok.
module maze_probe_addr
  import maze_pkg::*;
(
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  input  logic [2:0]  k,
  output logic [10:0] map_addr,
  output logic        oob,
  output logic        tunnel_ok
);

  localparam logic signed [10:0] REACH = 11'(BALL_S + STEP);
  localparam logic signed [10:0] HALF  = 11'(BALL_S);
  localparam logic signed [10:0] X_LIM = 11'(MAP_W << TILE_SHIFT);
  localparam logic signed [10:0] Y_LIM = 11'(MAP_H << TILE_SHIFT);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] x;
  logic signed [10:0] y;
  logic               x_out;
  logic               y_out;
  logic [10:0]        tx;
  logic [10:0]        ty;

  always_comb begin
    dx = '0;
    dy = '0;
    case (probe_dir(k))
      2'(DIR_L): begin dx = -REACH;               dy = k[0] ? HALF : -HALF; end
      2'(DIR_R): begin dx = REACH;                dy = k[0] ? HALF : -HALF; end
      2'(DIR_U): begin dx = k[0] ? HALF : -HALF;  dy = -REACH;              end
      default:   begin dx = k[0] ? HALF : -HALF;  dy = REACH;               end
    endcase

    x     = $signed({1'b0, px}) + dx;
    y     = $signed({1'b0, py}) + dy;
    x_out = (x < 0) || (x >= X_LIM);
    y_out = (y < 0) || (y >= Y_LIM);
    oob   = x_out | y_out;

    tx       = $unsigned(x) >> TILE_SHIFT;
    ty       = $unsigned(y) >> TILE_SHIFT;
    map_addr = oob ? '0 : (ty * 11'(MAP_W) + tx);

`ifdef MAZE_TUNNEL_WRAP_EN
    tunnel_ok = (probe_dir(k) == 2'(DIR_L) || probe_dir(k) == 2'(DIR_R)) && x_out && !y_out;
`else
    tunnel_ok = 1'b0;
`endif
  end

endmodule

// File: rtl/maze_wall_probe.sv
// Per-frame wall probe: samples the ball position, reads 8 corner tiles from the maze ROM and
// publishes the four "move open" flags together. Tunnel handling is selected by MAZE_TUNNEL_WRAP_EN.
module maze_wall_probe
  import maze_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  output logic [10:0] map_addr,
  input  logic        map_rdata,
  output logic        leftwall,
  output logic        rightwall,
  output logic        upwall,
  output logic        downwall,
  output logic        scan_done
);

  probe_state_t state, state_n;
  logic [2:0]   k, k_n;

  logic         sync_q1, sync_q2, sync_d;
  logic         frame_edge;
  logic         pending;
  logic [9:0]   px, py;
  logic [7:0]   wall;
  logic         prev_oob, prev_tun;
  logic         probe_wall;
  logic [10:0]  probe_addr;
  logic         oob, tunnel_ok;
  logic [3:0]   dir_open;

  assign frame_edge = sync_q2 & ~sync_d;

  maze_probe_addr u_probe_addr (
    .px        (px),
    .py        (py),
    .k         (k),
    .map_addr  (probe_addr),
    .oob       (oob),
    .tunnel_ok (tunnel_ok)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n   = state;
    k_n       = k;
    scan_done = 1'b0;
    map_addr  = '0;
    case (state)
      IDLE:    if (frame_edge) state_n = LATCH;
      LATCH: begin
        state_n = ISSUE;
        k_n     = '0;
      end
      ISSUE: begin
        map_addr = probe_addr;
        if (k == 3'(NUM_PROBES - 1)) state_n = DRAIN;
        else                         k_n     = k + 3'd1;
      end
      DRAIN:   state_n = PUBLISH;
      PUBLISH: begin
        scan_done = 1'b1;
        state_n   = (pending || frame_edge) ? LATCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Read data belongs to the probe issued last cycle, so its range flags are carried along.
  assign probe_wall = prev_oob ? ~prev_tun : map_rdata;

  always_comb begin
    dir_open = '0;
    for (int d = 0; d < 4; d++) begin
      dir_open[d] = ~(wall[2*d] | wall[2*d+1]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_d    <= 1'b0;
      pending   <= 1'b0;
      px        <= '0;
      py        <= '0;
      wall      <= '0;
      prev_oob  <= 1'b0;
      prev_tun  <= 1'b0;
      leftwall  <= 1'b0;
      rightwall <= 1'b0;
      upwall    <= 1'b0;
      downwall  <= 1'b0;
    end else begin
      sync_q1 <= frame_clk;
      sync_q2 <= sync_q1;
      sync_d  <= sync_q2;

      if (state == LATCH) begin
        px <= BallX;
        py <= BallY;
      end

      if (state == ISSUE) begin
        prev_oob <= oob;
        prev_tun <= tunnel_ok;
      end

      // Shift in results oldest-first; after 8 shifts probe 0 sits in bit 0.
      if ((state == ISSUE && k != 3'd0) || state == DRAIN)
        wall <= {probe_wall, wall[7:1]};

      if (state == PUBLISH) begin
        leftwall  <= dir_open[DIR_L];
        rightwall <= dir_open[DIR_R];
        upwall    <= dir_open[DIR_U];
        downwall  <= dir_open[DIR_D];
      end

      if (state == PUBLISH)
        pending <= 1'b0;
      else if (frame_edge && state != IDLE)
        pending <= 1'b1;
    end
  end

endmodule
